// File: rtl/button_pio_pkg.sv
// Shared definitions for the button input PIO: register addresses and the
// debounce counter width helper.
package button_pio_pkg;

    // Word addresses within the Avalon-MM slave.
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Width of a counter that must hold values 0..cycles.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage : button_pio_pkg

// File: rtl/button_pio_debounce.sv
// One-bit debouncer. The output follows the synchronised input only after it
// has disagreed with the current filtered level for DEBOUNCE_CYCLES
// consecutive cycles; any shorter excursion is discarded.
module button_pio_debounce
    import button_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
)(
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic filtered
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreement cycles; accept the new level on the last one.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            filtered <= 1'b0;
        end else if (sync == filtered) begin
            cnt      <= '0;
        end else if (cnt == CNT_LAST) begin
            filtered <= sync;
            cnt      <= '0;
        end else begin
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule : button_pio_debounce

// File: rtl/qsys_system_button_pio.sv
// Avalon-MM input PIO for the alarm-clock buttons and switches.
// Synchronises WIDTH raw pins, optionally debounces them, captures rising
// edges into a write-1-to-clear register and raises a maskable level IRQ.
// Optional debounce is enabled by defining BUTTON_PIO_DEBOUNCE_EN; without it
// the filtered level is simply the synchronised level delayed one cycle.
module qsys_system_button_pio
    import button_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;

    assign wr = chipselect & ~write_n;

    // Multi-stage synchroniser for the asynchronous pins. The chain is tiny and
    // must start at 0 so a pin held during reset is not seen early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= '0;
            end
        end else begin
            sync_ff[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // One debouncer per pin.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        button_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .sync     (sync[gi]),
            .filtered (filtered[gi])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Without debounce the filtered level is one register behind the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filtered <= '0;
        end else begin
            filtered <= sync;
        end
    end
`endif

    // Previous filtered level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= filtered;
        end
    end

    assign rise     = filtered & ~prev;
    assign edge_clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, written only through its own address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr && address == ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, with a coincident new rise taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | rise;
        end
    end

    // Zero-wait-state read mux; unused bits and the reserved word read as 0.
    // NOTE: defaulting every always_comb output first keeps a missed case
    // branch from inferring a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = filtered;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

    // Upper write-data bits have no register behind them when WIDTH < 32.
    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_writedata;
        assign unused_writedata = |writedata[31:WIDTH];
    end

endmodule : qsys_system_button_pio

// File: tb/tb_qsys_system_button_pio.sv
// Directed self-checking bench for qsys_system_button_pio
// (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4), with or without
// BUTTON_PIO_DEBOUNCE_EN.
module tb_qsys_system_button_pio;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DB    = 4;

    // Clock edges from an in_port change (applied just after an edge) until
    // EDGECAP shows the rise. Without debounce: 2 sync + 1 filtered + 1 capture.
    // With debounce: 2 sync + 4 counting edges (0,1,2,3 -> accept) + 1 capture.
`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int LAT_CAP = 7;
`else
    localparam int LAT_CAP = 4;
`endif
    localparam int LAT_DATA = LAT_CAP - 1;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    qsys_system_button_pio #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = 4'hF;
        tick(3);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rd); end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_edgecap: got %h want 0", rd); end
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_irqmask: got %h want 0", rd); end
        tick(1);
        reset = 1'b0;
        tick(LAT_DATA - 1);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_data_early: got %h want 0", rd); end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_edgecap_early: got %h want 0", rd); end
        tick(1);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'hF) begin bad++; $display("FAIL reset_data_settled: got %h want f", rd); end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_edgecap_pre: got %h want 0", rd); end
        tick(1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'hF) begin bad++; $display("FAIL reset_edgecap_late: got %h want f", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_unmasked: got %b want 0", irq); end
        in_port = 4'h0;
        tick(LAT_CAP + 2);
        write_reg(2'd3, 32'hF);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_cleanup_edgecap: got %h want 0", rd); end
    endtask

    task automatic test_capture_clear();
        write_reg(2'd2, 32'h1);
        in_port = 4'h1;
        tick(LAT_CAP - 1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cap_early: got %h want 0", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL cap_irq_early: got %b want 0", irq); end
        tick(1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cap_set: got %h want 1", rd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL cap_irq: got %b want 1", irq); end
        write_reg(2'd3, 32'h1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL cap_w1c_irq: got %b want 0", irq); end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cap_w1c: got %h want 0", rd); end
    endtask

    task automatic test_glitch();
`ifdef BUTTON_PIO_DEBOUNCE_EN
        in_port = 4'h3;
        tick(3);
        in_port = 4'h1;
        for (int i = 0; i < LAT_CAP + 2; i++) begin
            tick(1);
            read_reg(2'd0, rd);
            total++; if (rd !== 32'h1) begin bad++; $display("FAIL glitch_data[%0d]: got %h want 1", i, rd); end
        end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_edgecap: got %h want 0", rd); end
        in_port = 4'h3;
        tick(4);
        in_port = 4'h1;
        tick(LAT_CAP - 4);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL pulse4_edgecap: got %h want 2", rd); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL pulse4_data: got %h want 3", rd); end
`else
        in_port = 4'h3;
        tick(1);
        in_port = 4'h1;
        tick(LAT_CAP - 1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL pulse1_edgecap: got %h want 2", rd); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL pulse1_data: got %h want 1", rd); end
`endif
        tick(LAT_CAP + 2);
        write_reg(2'd3, 32'h2);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL pulse_clear: got %h want 0", rd); end
    endtask

    task automatic test_set_clear_collision();
        in_port = 4'h5;
        tick(LAT_CAP - 1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL coll_pre: got %h want 0", rd); end
        write_reg(2'd3, 32'h4);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL coll_set_wins: got %h want 4", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_irq_masked: got %b want 0", irq); end
        write_reg(2'd3, 32'h4);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL coll_clear: got %h want 0", rd); end
    endtask

    task automatic test_mask_regs();
        write_reg(2'd2, 32'h0);
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mask_zero: got %h want 0", rd); end
        in_port = 4'hD;
        tick(LAT_CAP);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL mask_pending: got %h want 8", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off: got %b want 0", irq); end
        write_reg(2'd2, 32'h8);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_on: got %b want 1", irq); end
        in_port = 4'h5;
        tick(LAT_CAP + 2);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL fall_edgecap: got %h want 8", rd); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h5) begin bad++; $display("FAIL fall_data: got %h want 5", rd); end
        read_reg(2'd1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsvd_read: got %h want 0", rd); end
        write_reg(2'd1, 32'hFFFF_FFFF);
        read_reg(2'd1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsvd_write: got %h want 0", rd); end
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL rsvd_mask_kept: got %h want 8", rd); end
        write_reg(2'd0, 32'hFFFF_FFFF);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h5) begin bad++; $display("FAIL data_write_ignored: got %h want 5", rd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_held: got %b want 1", irq); end
    endtask

    task automatic test_reset_mid();
        write_reg(2'd2, 32'hF);
        in_port = 4'h7;
        tick(LAT_CAP);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'hA) begin bad++; $display("FAIL mid_edgecap: got %h want a", rd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq: got %b want 1", irq); end
        reset = 1'b1;
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", rd); end
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_rst_mask: got %h want 0", rd); end
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_rst_edgecap: got %h want 0", rd); end
        tick(2);
        reset = 1'b0;
        tick(LAT_CAP - 1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_post_early: got %h want 0", rd); end
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL mid_post_data: got %h want 7", rd); end
        tick(1);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL mid_post_edgecap: got %h want 7", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_post_irq: got %b want 0", irq); end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        test_reset();
        test_capture_clear();
        test_glitch();
        test_set_clear_collision();
        test_mask_regs();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_qsys_system_button_pio
